vedic_div_64by32: RTL and testbench

- Sequential unsigned 64/32 restoring divider. It is the inverse companion to the 32x32 Vedic multiplier.
- Takes a 64-bit dividend and a 32-bit divisor. Returns a 32-bit quotient and a 32-bit remainder after 32 iteration cycles.
- Flags divide-by-zero and quotient overflow, completing in 1 cycle for those cases.
- Used to check multiplier products on a round trip and to serve divide ops on the datapath.

---
 rtl/vedic_div_64by32.sv | 184 ++++++++++++++++++
 tb/tb_vedic_div_64by32.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_div_64by32.sv
// ---------------------------------------------------------------------------
// vedic_div_64by32
//
// Sequential unsigned 2W/W restoring divider, the inverse companion of the
// WxW Vedic multiplier. One quotient bit is produced per clock, so a normal
// divide takes W iterations. Divide-by-zero and quotient overflow are caught
// at the accept edge and complete in a single cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; sampled only when busy is low (IDLE or FIN)
//   dividend     2W-bit dividend, captured on an accepted start
//   divisor      W-bit divisor, captured on an accepted start
//   busy         high while the iteration loop is running
//   done         one-cycle pulse; results valid from this cycle
//   quotient     W-bit quotient, held until the next accepted start
//   remainder    W-bit remainder, held until the next accepted start
//   div_by_zero  divisor was zero (takes priority over overflow), held
//   overflow     quotient would not fit in W bits, held
// ---------------------------------------------------------------------------
module vedic_div_64by32 #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(W);
    localparam int N  = W + 1;               // compare/subtract width
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t        state;
    logic [W-1:0]  r;            // partial remainder, always < divisor_r in RUN
    logic [W-1:0]  q;            // dividend low half shifting out, quotient shifting in
    logic [W-1:0]  divisor_r;
    logic [CW-1:0] count;

    // -----------------------------------------------------------------------
    // Trial subtract T - {0,divisor} as T + ~divisor + 1 over W+1 bits.
    // Every fourth carry is produced by 4-bit lookahead from the carry that
    // entered the nibble, so the long chain hops nibble to nibble; the carry
    // out (cla_c[N]) is set exactly when T >= divisor.
    // -----------------------------------------------------------------------
    logic [N-1:0] cla_a;
    logic [N-1:0] cla_b;
    logic [N-1:0] cla_g;
    logic [N-1:0] cla_p;
    logic [N:0]   cla_c;
    logic [W-1:0] diff;
    logic         take;
    logic [W-1:0] r_next;
    logic [W-1:0] q_next;

    // NOTE: every variable written in an always_comb gets a value on every
    // path (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        cla_a    = {r, q[W-1]};
        cla_b    = ~{1'b0, divisor_r};
        cla_g    = cla_a & cla_b;
        cla_p    = cla_a ^ cla_b;
        cla_c    = '0;
        cla_c[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if ((i % 4) == 3) begin
                cla_c[i+1] = cla_g[i]
                           | (cla_p[i] & cla_g[i-1])
                           | (cla_p[i] & cla_p[i-1] & cla_g[i-2])
                           | (cla_p[i] & cla_p[i-1] & cla_p[i-2] & cla_g[i-3])
                           | (cla_p[i] & cla_p[i-1] & cla_p[i-2] & cla_p[i-3] & cla_c[i-3]);
            end else begin
                cla_c[i+1] = cla_g[i] | (cla_p[i] & cla_c[i]);
            end
        end
        // Bit W of the difference is always 0 when taken (R < divisor), so
        // only the low W bits are kept.
        diff   = cla_p[W-1:0] ^ cla_c[W-1:0];
        take   = cla_c[N];
        r_next = take ? diff : {r[W-2:0], q[W-1]};
        q_next = {q[W-2:0], take};
    end

    // -----------------------------------------------------------------------
    // Control and result registers. Error cases are decided straight from
    // the operand inputs at the accept edge and jump directly to FIN.
    // -----------------------------------------------------------------------
    logic div_zero_in;
    logic ovf_in;

    always_comb begin
        div_zero_in = (divisor == '0);
        ovf_in      = (dividend[2*W-1:W] >= divisor);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    // NOTE: the working registers are reset along with the outputs; there is
    // no memory array here, so a full reset is cheap and leaves no X state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            count       <= '0;
            r           <= '0;
            q           <= '0;
            divisor_r   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        if (div_zero_in) begin
                            state       <= FIN;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[W-1:0];
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else if (ovf_in) begin
                            state       <= FIN;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end else begin
                            // quotient/remainder keep the previous result
                            // until the new one is complete.
                            state       <= RUN;
                            busy        <= 1'b1;
                            r           <= dividend[2*W-1:W];
                            q           <= dividend[W-1:0];
                            divisor_r   <= divisor;
                            count       <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state     <= FIN;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_div_64by32.sv
// ---------------------------------------------------------------------------
// tb_vedic_div_64by32
//
// Self-checking bench for vedic_div_64by32 (W=32). Expected results come
// from a plain-arithmetic reference (64-bit / and %) plus the flag and
// latency rules; random operands are built as a*b+r with r<b so the
// quotient and remainder are also known by construction.
// ---------------------------------------------------------------------------
module tb_vedic_div_64by32;

    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int n_checks = 0;
    int n_fail   = 0;

    vedic_div_64by32 #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what a 64/32 divide must return, with its flags and the
    // number of cycles from the accept edge to the done cycle.
    task automatic model(input logic [63:0] dd, input logic [31:0] dv,
                         output logic [31:0] eq, output logic [31:0] er,
                         output logic ez, output logic eo, output int el);
        logic [63:0] qq;
        logic [63:0] rr;
        if (dv == 0) begin
            eq = 32'hFFFF_FFFF; er = dd[31:0]; ez = 1'b1; eo = 1'b0; el = 1;
        end else if (dd[63:32] >= dv) begin
            eq = 32'hFFFF_FFFF; er = 32'h0; ez = 1'b0; eo = 1'b1; el = 1;
        end else begin
            qq = dd / {32'h0, dv};
            rr = dd % {32'h0, dv};
            eq = qq[31:0]; er = rr[31:0]; ez = 1'b0; eo = 1'b0; el = W + 1;
        end
    endtask

    // Present one start for one cycle; afterwards scramble the operand
    // inputs, which must not influence the accepted operation. Returns at
    // the first falling edge after the accept edge.
    task automatic launch(input logic [63:0] dd, input logic [31:0] dv);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = $urandom;
    endtask

    // Wait (bounded) for done, counting falling edges since the accept edge
    // and the cycles busy was seen high along the way.
    task automatic wait_done(input int lat0, output int lat, output int busy_n);
        lat    = lat0;
        busy_n = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [63:0] dd,
                                input logic [31:0] dv, input int lat);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        logic        eo;
        int          el;
        model(dd, dv, eq, er, ez, eo, el);
        check({tag, ".done"},      64'(done),        64'd1);
        check({tag, ".latency"},   64'(lat),         64'(el));
        check({tag, ".quotient"},  64'(quotient),    64'(eq));
        check({tag, ".remainder"}, 64'(remainder),   64'(er));
        check({tag, ".dbz"},       64'(div_by_zero), 64'(ez));
        check({tag, ".ovf"},       64'(overflow),    64'(eo));
        check({tag, ".busy"},      64'(busy),        64'd0);
    endtask

    task automatic run_op(input string tag, input logic [63:0] dd, input logic [31:0] dv);
        int lat;
        int bn;
        launch(dd, dv);
        wait_done(1, lat, bn);
        check_result(tag, dd, dv, lat);
    endtask

    initial begin
        int          lat;
        int          bn;
        logic [31:0] q_hold;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rr;
        logic [63:0] dd;
        logic [31:0] dv;
        bit          done_seen;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.quotient", 64'(quotient), 64'd0);
        check("reset.remainder", 64'(remainder), 64'd0);
        check("reset.flags", 64'({div_by_zero, overflow}), 64'd0);
        rst_n = 1'b1;

        // Basic 100/7 with busy length and single-cycle done
        launch(64'd100, 32'd7);
        wait_done(1, lat, bn);
        check_result("basic", 64'd100, 32'd7, lat);
        check("basic.busy_cycles", 64'(bn), 64'd32);
        q_hold = quotient;
        @(negedge clk);
        check("basic.done_pulse", 64'(done), 64'd0);
        check("basic.held", 64'(quotient), 64'(q_hold));
        check("basic.quotient_const", 64'(quotient), 64'd14);
        check("basic.remainder_const", 64'(remainder), 64'd2);

        // Round trips at the extremes
        run_op("maxprod", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
        check("maxprod.q_const", 64'(quotient), 64'hFFFF_FFFF);
        run_op("div1", 64'h0000_0000_DEAD_BEEF, 32'd1);
        check("div1.q_const", 64'(quotient), 64'hDEAD_BEEF);
        run_op("hi_eq_dv_minus1", 64'h0000_0FFF_FFFF_FFFF, 32'h0000_1000);

        // Error cases, including the div_by_zero-over-overflow priority
        launch(64'h1234_5678_9ABC_DEF0, 32'd0);
        wait_done(1, lat, bn);
        check_result("divzero", 64'h1234_5678_9ABC_DEF0, 32'd0, lat);
        check("divzero.busy_cycles", 64'(bn), 64'd0);
        check("divzero.rem_const", 64'(remainder), 64'h9ABC_DEF0);
        run_op("overflow", 64'h0000_0001_0000_0000, 32'd1);
        run_op("hi_eq_dv", 64'h0000_1000_0000_0005, 32'h0000_1000);
        run_op("after_err", 64'd1000, 32'd3);

        // start re-asserted during RUN is ignored
        launch(64'd100, 32'd7);
        repeat (4) @(negedge clk);
        dividend = 64'd999_999;
        divisor  = 32'd13;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(6, lat, bn);
        check_result("ignore_in_run", 64'd100, 32'd7, lat);

        // start held in the FIN cycle: back-to-back accept
        launch(64'h0000_0005_1234_5678, 32'h0001_0001);
        wait_done(1, lat, bn);
        check_result("b2b_first", 64'h0000_0005_1234_5678, 32'h0001_0001, lat);
        dividend = 64'h0000_0000_8765_4321;
        divisor  = 32'd12345;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        check("b2b.done_drop", 64'(done), 64'd0);
        check("b2b.busy_rise", 64'(busy), 64'd1);
        wait_done(1, lat, bn);
        check_result("b2b_second", 64'h0000_0000_8765_4321, 32'd12345, lat);

        // Error op back-to-back from FIN: done stays high a second cycle
        dividend = 64'h0000_0000_0000_0042;
        divisor  = 32'd0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        check_result("b2b_err", 64'h0000_0000_0000_0042, 32'd0, 1);

        // Reset in the middle of an operation
        launch(64'h0000_0001_2345_6789, 32'h0000_1000);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        check("midrst.quotient", 64'(quotient), 64'd0);
        check("midrst.remainder", 64'(remainder), 64'd0);
        check("midrst.flags", 64'({div_by_zero, overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        check("midrst.no_done", 64'(done_seen), 64'd0);
        run_op("post_rst", 64'd1000, 32'd10);
        check("post_rst.q_const", 64'(quotient), 64'd100);

        // Random round trips: dividend = a*b + r, r < b
        for (int k = 0; k < 250; k++) begin
            a  = $urandom;
            b  = (k % 2 == 0) ? $urandom : 32'($urandom_range(1, 255));
            if (b == 0) b = 32'd1;
            rr = $urandom % b;
            dd = {32'h0, a} * {32'h0, b} + {32'h0, rr};
            launch(dd, b);
            wait_done(1, lat, bn);
            check("rand.done", 64'(done), 64'd1);
            check("rand.latency", 64'(lat), 64'(W + 1));
            check("rand.quotient", 64'(quotient), 64'(a));
            check("rand.remainder", 64'(remainder), 64'(rr));
            check("rand.flags", 64'({div_by_zero, overflow}), 64'd0);
        end

        // Raw random operands, including some error cases
        for (int k = 0; k < 40; k++) begin
            dd = {$urandom, $urandom};
            dv = $urandom;
            if (k % 4 == 0) dd[63:32] = dd[63:32] >> 4;
            if (k % 10 == 3) dv = 32'd0;
            run_op("raw", dd, dv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
